// File: rtl/ctx_mem_pkg.sv
// Shared defaults and helpers for the multi-bank context memory.
package ctx_mem_pkg;

  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned DEF_DEPTH     = 64;
  localparam int unsigned DEF_NUM_BANKS = 4;

  // Ceiling log2; used for derived pointer and bank-select widths.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  // LSB position of bank b's field inside the packed bank_count bus.
  function automatic int unsigned cnt_lsb(input int unsigned bank, input int unsigned cnt_w);
    return bank * cnt_w;
  endfunction

endpackage

// File: rtl/ctx_bank.sv
// One circular-buffer context bank: storage, pointers, fill count and clear.
module ctx_bank
  import ctx_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned ADDR_W = clog2(DEF_DEPTH),
  parameter int unsigned CNT_W  = ADDR_W + 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              clr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              rd_acc
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              wr_acc;

  // Accept strobes: a clear on this bank drops any same-cycle access.
  always_comb begin
    full    = (count_q == CNT_W'(DEPTH));
    empty   = (count_q == '0);
    wr_acc  = wr_req & ~full & ~clr;
    rd_acc  = rd_req & ~empty & ~clr;
    rd_data = mem[rptr_q];
    count   = count_q;
  end

  // Storage is intentionally not reset.
  always_ff @(posedge sys_clk) begin
    if (wr_acc) mem[wptr_q] <= wr_data;
  end

  // Pointers and fill count; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clr) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wptr_q <= wptr_q + ADDR_W'(1);
      if (rd_acc) rptr_q <= rptr_q + ADDR_W'(1);
      if (wr_acc && !rd_acc) count_q <= count_q + CNT_W'(1);
      else if (rd_acc && !wr_acc) count_q <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/ctx_mem_bank_ctrl.sv
// Multi-bank context memory with registered read path and inline PCI bypass.
module ctx_mem_bank_ctrl
  import ctx_mem_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned NUM_BANKS = DEF_NUM_BANKS,
  parameter int unsigned ADDR_W    = clog2(DEPTH),
  parameter int unsigned BANK_W    = clog2(NUM_BANKS),
  parameter int unsigned CNT_W     = ADDR_W + 1
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       context_en,
  input  logic                       wr_en,
  input  logic [BANK_W-1:0]          wr_bank,
  input  logic                       rd_en,
  input  logic [BANK_W-1:0]          rd_bank,
  input  logic [DATA_W-1:0]          pci_data_in,
  input  logic [NUM_BANKS-1:0]       bank_clr,
  input  logic                       err_clr,
  output logic [DATA_W-1:0]          pci_context_data,
  output logic                       ctx_valid,
  output logic [NUM_BANKS-1:0]       bank_full,
  output logic [NUM_BANKS-1:0]       bank_empty,
  output logic [NUM_BANKS*CNT_W-1:0] bank_count,
  output logic                       overflow_err,
  output logic                       underflow_err
);

  logic [NUM_BANKS-1:0] wr_req, rd_req, rd_acc;
  logic [DATA_W-1:0]    bank_rdata [NUM_BANKS];
  logic [DATA_W-1:0]    rd_mux, rd_data_q;
  logic                 ctx_valid_q, ovf_q, unf_q;
  logic                 ovf_evt, unf_evt;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    // Out-of-range bank indices match no bank and are silently ignored.
    assign wr_req[b] = context_en & wr_en & (wr_bank == BANK_W'(b));
    assign rd_req[b] = context_en & rd_en & (rd_bank == BANK_W'(b));

    ctx_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
    ) u_bank (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .wr_req    (wr_req[b]),
      .rd_req    (rd_req[b]),
      .clr       (bank_clr[b]),
      .wr_data   (pci_data_in),
      .rd_data   (bank_rdata[b]),
      .full      (bank_full[b]),
      .empty     (bank_empty[b]),
      .count     (bank_count[cnt_lsb(b, CNT_W) +: CNT_W]),
      .rd_acc    (rd_acc[b])
    );
  end

  // Select the accepted bank's head entry and detect rejected accesses.
  always_comb begin
    rd_mux = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rd_acc[b]) rd_mux = bank_rdata[b];
    end
    ovf_evt = |(wr_req & bank_full & ~bank_clr);
    unf_evt = |(rd_req & bank_empty & ~bank_clr);
  end

  // Registered read path, valid strobe and sticky errors (set beats clear).
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_data_q   <= '0;
      ctx_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      ctx_valid_q <= |rd_acc;
      if (|rd_acc) rd_data_q <= rd_mux;
      ovf_q <= ovf_evt | (ovf_q & ~err_clr);
      unf_q <= unf_evt | (unf_q & ~err_clr);
    end
  end

  assign ctx_valid        = ctx_valid_q;
  assign overflow_err     = ovf_q;
  assign underflow_err    = unf_q;
  assign pci_context_data = (ctx_valid_q & context_en) ? rd_data_q : pci_data_in;

endmodule

// File: tb/tb_ctx_mem_bank_ctrl.sv
// Self-checking bench for ctx_mem_bank_ctrl against a queue-based reference model.
module tb_ctx_mem_bank_ctrl;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int NB     = 4;
  localparam int CNT_W  = 7;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              context_en = 1'b0, wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
  logic [1:0]        wr_bank = '0, rd_bank = '0;
  logic [DATA_W-1:0] pci_data_in = '0;
  logic [NB-1:0]     bank_clr = '0;
  logic [DATA_W-1:0] pci_context_data;
  logic              ctx_valid, overflow_err, underflow_err;
  logic [NB-1:0]     bank_full, bank_empty;
  logic [NB*CNT_W-1:0] bank_count;

  int errors = 0;
  int checks = 0;

  // Reference model: one FIFO queue per bank plus expected registered outputs.
  logic [DATA_W-1:0] mq [NB][$];
  logic              exp_valid = 1'b0, exp_ovf = 1'b0, exp_unf = 1'b0;
  logic [DATA_W-1:0] exp_rdata = '0;

  always #5 sys_clk = ~sys_clk;

  ctx_mem_bank_ctrl dut (
    .sys_clk          (sys_clk),
    .sys_rst_n        (sys_rst_n),
    .context_en       (context_en),
    .wr_en            (wr_en),
    .wr_bank          (wr_bank),
    .rd_en            (rd_en),
    .rd_bank          (rd_bank),
    .pci_data_in      (pci_data_in),
    .bank_clr         (bank_clr),
    .err_clr          (err_clr),
    .pci_context_data (pci_context_data),
    .ctx_valid        (ctx_valid),
    .bank_full        (bank_full),
    .bank_empty       (bank_empty),
    .bank_count       (bank_count),
    .overflow_err     (overflow_err),
    .underflow_err    (underflow_err)
  );

  function automatic int cnt(input int b);
    return int'(bank_count[b*CNT_W +: CNT_W]);
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) mq[b].delete();
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
    exp_rdata = '0;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; bank_clr = '0; err_clr = 1'b0;
    @(posedge sys_clk); #1;
    model_reset();
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
  endtask

  // Drive one cycle of stimulus, advance the model, then return #1 after the edge.
  task automatic step(input logic ce, input logic we, input int wb, input logic re,
                      input int rb, input logic [DATA_W-1:0] din, input logic [NB-1:0] clr,
                      input logic eclr);
    logic rd_ok, wr_ok, ov, un;
    context_en = ce; wr_en = we; wr_bank = 2'(wb); rd_en = re; rd_bank = 2'(rb);
    pci_data_in = din; bank_clr = clr; err_clr = eclr;
    rd_ok = ce && re && mq[rb].size() != 0 && !clr[rb];
    wr_ok = ce && we && mq[wb].size() < DEPTH && !clr[wb];
    ov    = ce && we && mq[wb].size() == DEPTH && !clr[wb];
    un    = ce && re && mq[rb].size() == 0 && !clr[rb];
    exp_valid = rd_ok;
    if (rd_ok) exp_rdata = mq[rb].pop_front();
    if (wr_ok) mq[wb].push_back(din);
    for (int b = 0; b < NB; b++) if (clr[b]) mq[b].delete();
    exp_ovf = ov || (exp_ovf && !eclr);
    exp_unf = un || (exp_unf && !eclr);
    @(posedge sys_clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; bank_clr = '0; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    pci_data_in = 32'hCAFE_F00D;
    context_en  = 1'b1;
    do_reset();
    checks++; if (bank_empty !== 4'hF) begin errors++;
      $display("FAIL reset_empty: got %b expected 1111", bank_empty); end
    checks++; if (bank_full !== 4'h0) begin errors++;
      $display("FAIL reset_full: got %b expected 0000", bank_full); end
    checks++; if (bank_count !== '0) begin errors++;
      $display("FAIL reset_count: got %h expected 0", bank_count); end
    checks++; if ({ctx_valid, overflow_err, underflow_err} !== 3'b000) begin errors++;
      $display("FAIL reset_flags: got %b expected 000",
               {ctx_valid, overflow_err, underflow_err}); end
    checks++; if (pci_context_data !== 32'hCAFE_F00D) begin errors++;
      $display("FAIL reset_bypass: got %h expected cafef00d", pci_context_data); end
  endtask

  task automatic test_fifo_order();
    for (int i = 0; i < 4; i++) step(1, 1, 2, 0, 0, 32'hA000_0000 + i, '0, 0);
    checks++; if (cnt(2) !== 4) begin errors++;
      $display("FAIL fifo_count4: got %0d expected 4", cnt(2)); end
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 1, 2, 32'h0, '0, 0);
      checks++; if (ctx_valid !== 1'b1 || pci_context_data !== 32'hA000_0000 + i) begin
        errors++;
        $display("FAIL fifo_read%0d: got v=%b d=%h expected v=1 d=%h", i, ctx_valid,
                 pci_context_data, 32'hA000_0000 + i);
      end
    end
    step(1, 0, 0, 0, 0, 32'h0, '0, 0);
    checks++; if (ctx_valid !== 1'b0) begin errors++;
      $display("FAIL fifo_valid_pulse: got %b expected 0", ctx_valid); end
    checks++; if (cnt(2) !== 0 || bank_empty[2] !== 1'b1) begin errors++;
      $display("FAIL fifo_drain: got cnt=%0d empty=%b expected 0/1", cnt(2), bank_empty[2]); end
  endtask

  task automatic test_overflow();
    int bad;
    for (int i = 0; i < DEPTH; i++) step(1, 1, 0, 0, 0, 32'hB000_0000 + i, '0, 0);
    checks++; if (bank_full[0] !== 1'b1 || cnt(0) !== DEPTH) begin errors++;
      $display("FAIL ovf_full: got full=%b cnt=%0d expected 1/64", bank_full[0], cnt(0)); end
    step(1, 1, 0, 0, 0, 32'h0000_DEAD, '0, 0);
    checks++; if (overflow_err !== 1'b1 || cnt(0) !== DEPTH) begin errors++;
      $display("FAIL ovf_reject: got err=%b cnt=%0d expected 1/64", overflow_err, cnt(0)); end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 0, 1, 0, 32'h0, '0, 0);
      if (ctx_valid !== 1'b1 || pci_context_data !== 32'hB000_0000 + i) bad++;
    end
    checks++; if (bad != 0) begin errors++;
      $display("FAIL ovf_readback: got %0d bad reads expected 0", bad); end
    // Pointers wrapped: a fresh entry must come back intact.
    step(1, 1, 0, 0, 0, 32'h7777_0001, '0, 0);
    step(1, 0, 0, 1, 0, 32'h0, '0, 1);
    checks++; if (pci_context_data !== 32'h7777_0001 || overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL ovf_wrap: got d=%h err=%b expected 77770001/0", pci_context_data,
               overflow_err);
    end
  endtask

  task automatic test_underflow();
    step(1, 1, 1, 1, 1, 32'h55, '0, 0);
    checks++; if (underflow_err !== 1'b1 || ctx_valid !== 1'b0 || cnt(1) !== 1) begin
      errors++;
      $display("FAIL unf_reject: got err=%b v=%b cnt=%0d expected 1/0/1", underflow_err,
               ctx_valid, cnt(1));
    end
    step(1, 0, 0, 1, 1, 32'h0, '0, 0);
    checks++; if (ctx_valid !== 1'b1 || pci_context_data !== 32'h55) begin errors++;
      $display("FAIL unf_readback: got v=%b d=%h expected 1/55", ctx_valid, pci_context_data);
    end
    // New underflow together with err_clr: set wins.
    step(1, 0, 0, 1, 1, 32'h0, '0, 1);
    checks++; if (underflow_err !== 1'b1) begin errors++;
      $display("FAIL unf_set_wins: got %b expected 1", underflow_err); end
    step(1, 0, 0, 0, 0, 32'h0, '0, 1);
    checks++; if (underflow_err !== 1'b0) begin errors++;
      $display("FAIL unf_clear: got %b expected 0", underflow_err); end
  endtask

  task automatic test_back_to_back();
    step(1, 1, 0, 0, 0, 32'h100, '0, 0);
    step(1, 1, 0, 0, 0, 32'h101, '0, 0);
    step(1, 1, 3, 1, 0, 32'h11, '0, 0);
    checks++; if (cnt(3) !== 1 || cnt(0) !== 1) begin errors++;
      $display("FAIL b2b_counts: got c3=%0d c0=%0d expected 1/1", cnt(3), cnt(0)); end
    checks++; if (ctx_valid !== 1'b1 || pci_context_data !== 32'h100) begin errors++;
      $display("FAIL b2b_data: got v=%b d=%h expected 1/100", ctx_valid, pci_context_data); end
    checks++; if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin errors++;
      $display("FAIL b2b_errs: got %b%b expected 00", overflow_err, underflow_err); end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 5; i++) step(1, 1, 2, 0, 0, 32'hC0 + i, '0, 0);
    step(1, 1, 2, 1, 2, 32'hBAD, 4'b0100, 0);
    checks++; if (cnt(2) !== 0 || bank_empty[2] !== 1'b1) begin errors++;
      $display("FAIL clr_bank2: got cnt=%0d expected 0", cnt(2)); end
    checks++; if (cnt(0) !== 1 || cnt(1) !== 0 || cnt(3) !== 1) begin errors++;
      $display("FAIL clr_others: got %0d/%0d/%0d expected 1/0/1", cnt(0), cnt(1), cnt(3)); end
    checks++; if ({ctx_valid, overflow_err, underflow_err} !== 3'b000) begin errors++;
      $display("FAIL clr_flags: got %b expected 000",
               {ctx_valid, overflow_err, underflow_err}); end
  endtask

  task automatic test_bypass_and_reset();
    step(0, 1, 0, 1, 0, 32'h1234_5678, '0, 0);
    checks++; if (pci_context_data !== 32'h1234_5678 || ctx_valid !== 1'b0) begin errors++;
      $display("FAIL byp_data: got d=%h v=%b expected 12345678/0", pci_context_data,
               ctx_valid);
    end
    checks++; if (cnt(0) !== 1 || overflow_err !== 1'b0 || underflow_err !== 1'b0) begin
      errors++;
      $display("FAIL byp_nochange: got cnt=%0d errs=%b%b expected 1/00", cnt(0),
               overflow_err, underflow_err);
    end
    step(1, 1, 1, 1, 0, 32'h9, '0, 0);
    checks++; if (ctx_valid !== 1'b1) begin errors++;
      $display("FAIL rst_precond: got %b expected 1", ctx_valid); end
    sys_rst_n = 1'b0;
    #1;
    checks++; if (bank_count !== '0 || ctx_valid !== 1'b0 || bank_empty !== 4'hF) begin
      errors++;
      $display("FAIL rst_async: got cnt=%h v=%b empty=%b expected 0/0/1111", bank_count,
               ctx_valid, bank_empty);
    end
    model_reset();
    #3 sys_rst_n = 1'b1;
  endtask

  task automatic test_random();
    int wp, rp, b, bad_before;
    logic [DATA_W-1:0] exp_out;
    do_reset();
    for (int ph = 0; ph < 10; ph++) begin
      wp = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 50 : 20;
      rp = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 50 : 85;
      for (int n = 0; n < 200; n++) begin
        step(($urandom_range(0, 9) != 0), ($urandom_range(0, 99) < wp),
             int'($urandom_range(0, 3)), ($urandom_range(0, 99) < rp),
             int'($urandom_range(0, 3)), $urandom(),
             ($urandom_range(0, 31) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0,
             ($urandom_range(0, 15) == 0));
        exp_out = (exp_valid && context_en) ? exp_rdata : pci_data_in;
        checks++; if (ctx_valid !== exp_valid || pci_context_data !== exp_out) begin
          errors++;
          $display("FAIL rnd_out ph%0d n%0d: got v=%b d=%h expected v=%b d=%h", ph, n,
                   ctx_valid, pci_context_data, exp_valid, exp_out);
        end
        checks++; if (overflow_err !== exp_ovf || underflow_err !== exp_unf) begin
          errors++;
          $display("FAIL rnd_err ph%0d n%0d: got %b%b expected %b%b", ph, n, overflow_err,
                   underflow_err, exp_ovf, exp_unf);
        end
        bad_before = errors;
        for (b = 0; b < NB; b++) begin
          checks++;
          if (cnt(b) !== mq[b].size() || bank_full[b] !== (mq[b].size() == DEPTH) ||
              bank_empty[b] !== (mq[b].size() == 0)) begin
            errors++;
            $display("FAIL rnd_bank%0d ph%0d n%0d: got cnt=%0d f=%b e=%b expected cnt=%0d",
                     b, ph, n, cnt(b), bank_full[b], bank_empty[b], mq[b].size());
          end
        end
        if (errors > bad_before + 20) break;
      end
    end
  endtask

  initial begin
    test_reset();
    test_fifo_order();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_clear();
    test_bypass_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #2_000_000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1);
  end

endmodule
